if_fetch: RTL and testbench

Instruction-fetch stage of the single-cycle RV32 core. Owns the architectural PC register, drives the current PC into the next-PC logic, and loads the returned next PC. Fetches one instruction per request from the instruction memory over a req/ack handshake, then buffers {pc, instr} pairs in a small FIFO for decode. A control-flow redirect flushes the buffer and squashes any in-flight fetch.

---
 rtl/if_fetch_pkg.sv | 31 +++
 rtl/if_fetch_fifo.sv | 86 ++++++++
 rtl/if_fetch.sv | 150 +++++++++++++++
 tb/tb_if_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch FSM state encoding
//   - default reset PC and buffer depth
//   - the {pc, instr} entry layout stored in the fetch buffer
//   - a word-alignment helper used for redirect targets
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,   // no request outstanding
        IF_WAIT = 2'd1,   // request outstanding, result wanted
        IF_DROP = 2'd2    // request outstanding, result to be discarded
    } fetch_state_e;

    localparam logic [31:0] IF_RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int          IF_BUF_DEPTH_DEFAULT = 2;

    // One buffered fetch: 64 bits, PC in the upper half.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Clear the byte-offset bits so the PC always points at a word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small FIFO holding fetched {pc, instr} entries for decode.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the tail (ignored when flush is high)
//   push_data   64-bit entry
//   pop         retire the head entry (ignored when flush is high or empty)
//   flush       discard all entries; has priority over push and pop
//   head_data   current head entry (all zeros after reset)
//   valid       FIFO not empty
//   count       number of stored entries
// Pointers are $clog2(DEPTH) bits wide and wrap naturally because DEPTH is a
// power of two. Storage is a handful of flops, so it is reset and read
// asynchronously from the registered array.
// ---------------------------------------------------------------------------
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = IF_BUF_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign valid     = (count_reg != '0);
    assign count     = count_reg;

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage: owns the PC, fetches one instruction per request
// over a req/ack handshake and buffers {pc, instr} pairs for decode. A
// redirect flushes the buffer and squashes any in-flight fetch.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pc_o            current fetch PC (to next-PC logic)
//   npc_i           next PC from next-PC logic
//   redirect_i      taken branch/jump; npc_i holds the target
//   imem_req_o      fetch request, held until ack
//   imem_addr_o     address of the outstanding request
//   imem_ack_i      one-cycle response strobe
//   imem_rdata_i    instruction, valid with ack
//   inst_valid_o    buffer head valid
//   inst_o          head instruction
//   inst_pc_o       head PC
//   inst_ready_i    decode accepts head
//   fetch_fault_o   one-cycle pulse after a misaligned redirect target
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = IF_BUF_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_o,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic        fetch_fault_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  addr_reg, addr_next;
    logic         fault_reg, fault_next;

    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_in;
    logic             fifo_valid;
    logic [CNT_W-1:0] fifo_count;

    logic             busy;
    logic [CNT_W:0]   occupancy;
    logic             credit;

    // Buffered entries plus the one in flight must fit, so an issued fetch
    // always has a slot waiting for it.
    assign busy      = (state_reg != IF_IDLE);
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, busy};
    assign credit    = (occupancy < (CNT_W+1)'(BUF_DEPTH));

    assign fifo_in.pc    = pc_reg;
    assign fifo_in.instr = imem_rdata_i;

    // Flush beats pop: the head is not consumed in a redirect cycle.
    assign fifo_pop = fifo_valid & inst_ready_i & ~redirect_i;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        addr_next  = addr_reg;
        fifo_push  = 1'b0;
        fault_next = redirect_i & (npc_i[1:0] != 2'b00);

        if (redirect_i) begin
            pc_next = align_word(npc_i);
        end

        case (state_reg)
            IF_IDLE: begin
                if (!redirect_i && credit) begin
                    state_next = IF_WAIT;
                    addr_next  = pc_reg;
                end
            end
            IF_WAIT: begin
                if (redirect_i) begin
                    // Squash: a same-cycle ack is simply not pushed.
                    state_next = imem_ack_i ? IF_IDLE : IF_DROP;
                end else if (imem_ack_i) begin
                    fifo_push  = 1'b1;
                    pc_next    = npc_i;
                    state_next = IF_IDLE;
                end
            end
            IF_DROP: begin
                // Keep the stale request up until memory answers, then
                // throw the data away.
                if (imem_ack_i) begin
                    state_next = IF_IDLE;
                end
            end
            default: begin
                state_next = IF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IF_IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            fault_reg <= fault_next;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .flush     (redirect_i),
        .head_data (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign pc_o          = pc_reg;
    assign imem_req_o    = busy;
    assign imem_addr_o   = addr_reg;
    assign inst_valid_o  = fifo_valid;
    assign inst_o        = fifo_head.instr;
    assign inst_pc_o     = fifo_head.pc;
    assign fetch_fault_o = fault_reg;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch (RESET_PC=0, BUF_DEPTH=2). Memory returns
// 32'hA000_0000 | addr; npc_i is pc_o+4 unless a redirect target is forced.
// Inputs change and outputs are checked on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    logic        auto_ack  = 1'b0;
    logic        man_ack   = 1'b0;
    logic        redir     = 1'b0;
    logic [31:0] npc_force = 32'h0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Zero-wait memory when auto_ack is set; otherwise acks are hand-driven.
    assign imem_ack   = (auto_ack & imem_req) | man_ack;
    assign imem_rdata = 32'hA000_0000 | imem_addr;
    assign redirect   = redir;
    assign npc        = redir ? npc_force : pc + 32'd4;

    if_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_o          (pc),
        .npc_i         (npc),
        .redirect_i    (redirect),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .inst_pc_o     (inst_pc),
        .inst_ready_i  (inst_ready),
        .fetch_fault_o (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        auto_ack   = 1'b0;
        man_ack    = 1'b0;
        redir      = 1'b0;
        npc_force  = 32'h0;
        inst_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        inst_ready = 1'b1;

        // ---- 1: reset values and sequential fetch 0,4,8 -------------------
        do_reset();
        auto_ack = 1'b1;
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_pc",    pc,                   32'h0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", {31'b0, inst_valid},  32'h0);
        chk("rst_inst",  inst,                 32'h0);
        chk("rst_ipc",   inst_pc,              32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
        tick();
        chk("seq_req0",  {31'b0, imem_req},    32'h1);
        chk("seq_addr0", imem_addr,            32'h0);
        tick();
        chk("seq_valid0", {31'b0, inst_valid}, 32'h1);
        chk("seq_ipc0",   inst_pc,             32'h0);
        chk("seq_inst0",  inst,                32'hA000_0000);
        chk("seq_reqlo",  {31'b0, imem_req},   32'h0);
        chk("seq_pc4",    pc,                  32'h4);
        tick();
        chk("seq_addr4",  imem_addr,           32'h4);
        chk("seq_req4",   {31'b0, imem_req},   32'h1);
        tick();
        chk("seq_ipc4",   inst_pc,             32'h4);
        tick();
        chk("seq_addr8",  imem_addr,           32'h8);
        tick();
        chk("seq_ipc8",   inst_pc,             32'h8);
        chk("seq_inst8",  inst,                32'hA000_0008);
        $display("txn seq: fetched 0,4,8");

        // ---- 2: back-pressure fills 2 entries, then drains ----------------
        do_reset();
        inst_ready = 1'b0;
        auto_ack   = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_noreq", {31'b0, imem_req}, 32'h0);
        end
        chk("full_valid", {31'b0, inst_valid}, 32'h1);
        chk("full_ipc0",  inst_pc,             32'h0);
        chk("full_pc8",   pc,                  32'h8);
        inst_ready = 1'b1;
        tick();
        chk("drain_ipc4",   inst_pc,            32'h4);
        chk("drain_noreq",  {31'b0, imem_req},  32'h0);
        tick();
        chk("drain_empty",  {31'b0, inst_valid}, 32'h0);
        chk("drain_req",    {31'b0, imem_req},   32'h1);
        chk("drain_addr8",  imem_addr,           32'h8);
        $display("txn backpressure: drained 0,4, resumed at 8");

        // ---- 3: redirect during WAIT, ack 3 cycles later -----------------
        do_reset();
        auto_ack = 1'b1;
        repeat (4) tick();
        auto_ack = 1'b0;
        tick();
        chk("drop_pre_addr", imem_addr, 32'h8);
        redir     = 1'b1;
        npc_force = 32'h100;
        tick();
        redir = 1'b0;
        chk("drop_req",   {31'b0, imem_req},   32'h1);
        chk("drop_addr",  imem_addr,           32'h8);
        chk("drop_pc",    pc,                  32'h100);
        chk("drop_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        tick();
        chk("drop_hold",  imem_addr,           32'h8);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("drop_idle",   {31'b0, imem_req},   32'h0);
        chk("drop_nostale",{31'b0, inst_valid}, 32'h0);
        chk("drop_pc2",    pc,                  32'h100);
        tick();
        chk("drop_nreq",   {31'b0, imem_req},   32'h1);
        chk("drop_naddr",  imem_addr,           32'h100);
        $display("txn redirect-wait: stale 0x8 dropped, refetch 0x100");

        // ---- 4: redirect in the same cycle as ack -------------------------
        do_reset();
        auto_ack = 1'b1;
        repeat (5) tick();
        chk("same_pre_addr", imem_addr, 32'h8);
        redir     = 1'b1;
        npc_force = 32'h100;
        tick();
        redir = 1'b0;
        chk("same_noreq", {31'b0, imem_req},    32'h0);
        chk("same_valid", {31'b0, inst_valid},  32'h0);
        chk("same_pc",    pc,                   32'h100);
        chk("same_fault", {31'b0, fetch_fault}, 32'h0);
        tick();
        chk("same_addr",  imem_addr,            32'h100);
        tick();
        chk("same_ipc",   inst_pc,              32'h100);
        chk("same_inst",  inst,                 32'hA000_0100);
        $display("txn redirect-ack: no DROP, fetched 0x100");

        // ---- 5: misaligned redirect target -------------------------------
        do_reset();
        redir     = 1'b1;
        npc_force = 32'h102;
        tick();
        redir = 1'b0;
        chk("mis_pc",     pc,                   32'h100);
        chk("mis_fault1", {31'b0, fetch_fault}, 32'h1);
        chk("mis_noreq",  {31'b0, imem_req},    32'h0);
        tick();
        chk("mis_fault0", {31'b0, fetch_fault}, 32'h0);
        chk("mis_addr",   imem_addr,            32'h100);
        $display("txn misaligned: pc 0x100, one-cycle fault");

        // ---- 6: reset during WAIT, late ack ignored -----------------------
        do_reset();
        auto_ack = 1'b1;
        repeat (3) tick();
        auto_ack = 1'b0;
        chk("mrst_pre_addr", imem_addr, 32'h4);
        rst = 1'b1;
        #1;
        chk("mrst_req",   {31'b0, imem_req},   32'h0);
        chk("mrst_pc",    pc,                  32'h0);
        chk("mrst_addr",  imem_addr,           32'h0);
        chk("mrst_valid", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("mrst_ign_valid", {31'b0, inst_valid}, 32'h0);
        chk("mrst_new_req",   {31'b0, imem_req},   32'h1);
        chk("mrst_new_addr",  imem_addr,           32'h0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("mrst_valid1", {31'b0, inst_valid}, 32'h1);
        chk("mrst_ipc",    inst_pc,             32'h0);
        chk("mrst_inst",   inst,                32'hA000_0000);
        $display("txn reset-wait: late ack ignored, refetch at 0x0");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
